// File: rtl/xosera_bus_initiator.sv
// Host-side initiator for the Xosera 8-bit register bus.
// Splits word/byte requests into DTACK-paced byte cycles, even byte first.
module xosera_bus_initiator #(
  parameter int SETUP_CYCLES    = 2,
  parameter int STROBE_MIN      = 2,
  parameter int RECOVERY_CYCLES = 2,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int TW              = 8
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rd_nwr_i,
  input  logic        req_word_i,
  input  logic        req_odd_i,
  input  logic [3:0]  req_reg_i,
  input  logic [15:0] req_data_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic [4:0]  bus_addr_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_dtack_n_i
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, RELEASE, RECOVER, DONE
  } state_t;

  localparam logic [TW-1:0] SETUP_N = TW'(SETUP_CYCLES);
  localparam logic [TW-1:0] SMIN_N  = TW'(STROBE_MIN);
  localparam logic [TW-1:0] RECOV_N = TW'(RECOVERY_CYCLES);
  localparam logic [TW-1:0] TMO_N   = TW'(TIMEOUT_CYCLES);

  state_t        state;
  logic [TW-1:0] cnt;
  logic [TW-1:0] cnt_inc;
  logic [1:0]    sync;
  logic          dtk;
  logic          l_rd;
  logic          l_word;
  logic [7:0]    l_lo;
  logic          abort;
  logic [15:0]   rd_buf;

  assign dtk     = sync[1];
  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) sync <= 2'b11;
    else         sync <= {sync[0], bus_dtack_n_i};
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state         <= IDLE;
      cnt           <= '0;
      l_rd          <= 1'b1;
      l_word        <= 1'b0;
      l_lo          <= '0;
      abort         <= 1'b0;
      rd_buf        <= '0;
      req_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= '0;
      rsp_err_o     <= 1'b0;
      bus_cs_n_o    <= 1'b1;
      bus_rd_nwr_o  <= 1'b1;
      bus_addr_o    <= '0;
      bus_data_o    <= '0;
      bus_data_oe_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            l_rd          <= req_rd_nwr_i;
            l_word        <= req_word_i;
            l_lo          <= req_data_i[7:0];
            abort         <= 1'b0;
            rd_buf        <= '0;
            rsp_err_o     <= 1'b0;
            req_ready_o   <= 1'b0;
            bus_rd_nwr_o  <= req_rd_nwr_i;
            bus_addr_o    <= {req_reg_i, ~req_word_i & req_odd_i};
            bus_data_o    <= (!req_word_i && req_odd_i) ?
                             req_data_i[7:0] : req_data_i[15:8];
            bus_data_oe_o <= !req_rd_nwr_i;
            cnt           <= '0;
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_inc >= SETUP_N) begin
            bus_cs_n_o <= 1'b0;
            cnt        <= '0;
            state      <= STROBE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        STROBE: begin
          if (!dtk && cnt_inc >= SMIN_N) begin
            if (l_rd) begin
              if (bus_addr_o[0]) rd_buf[7:0]  <= bus_data_i;
              else               rd_buf[15:8] <= bus_data_i;
            end
            bus_cs_n_o <= 1'b1;
            cnt        <= '0;
            state      <= RELEASE;
          end else if (cnt_inc >= TMO_N) begin
            bus_cs_n_o    <= 1'b1;
            bus_data_oe_o <= 1'b0;
            rsp_err_o     <= 1'b1;
            abort         <= 1'b1;
            cnt           <= '0;
            state         <= RECOVER;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RELEASE: begin
          // write data stays on the bus until the target lets go of DTACK
          if (dtk) begin
            bus_data_oe_o <= 1'b0;
            cnt           <= '0;
            state         <= RECOVER;
          end else if (cnt_inc >= TMO_N) begin
            bus_data_oe_o <= 1'b0;
            rsp_err_o     <= 1'b1;
            abort         <= 1'b1;
            cnt           <= '0;
            state         <= RECOVER;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RECOVER: begin
          if (cnt_inc >= RECOV_N) begin
            cnt <= '0;
            if (l_word && !bus_addr_o[0] && !abort) begin
              bus_addr_o[0] <= 1'b1;
              bus_data_o    <= l_lo;
              bus_data_oe_o <= !l_rd;
              state         <= SETUP;
            end else begin
              rsp_valid_o <= 1'b1;
              if (l_rd) rsp_data_o <= rd_buf;
              state <= DONE;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE: begin
          rsp_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xosera_bus_initiator.sv
// Bench for xosera_bus_initiator: target model on the byte bus,
// scoreboard queues for bus cycles and responses.
module tb_xosera_bus_initiator;

  localparam int SETUP = 2;
  localparam int SMIN  = 2;
  localparam int REC   = 2;
  localparam int TMO   = 16;

  typedef struct packed {
    logic [4:0] addr;
    logic       rd;
    logic [7:0] data;
    logic       oe;
  } bus_t;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rd_nwr = 1'b0;
  logic        req_word = 1'b0;
  logic        req_odd = 1'b0;
  logic [3:0]  req_reg = '0;
  logic [15:0] req_data = '0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        bus_cs_n;
  logic        bus_rd_nwr;
  logic [4:0]  bus_addr;
  logic [7:0]  bus_data_o;
  logic        bus_data_oe;
  logic [7:0]  bus_din = '0;
  logic        bus_dtack_n;

  int total = 0;
  int passed = 0;

  int cyc = 0;
  int acc_cyc = 0;
  int rsp_cyc = 0;
  int rsp_cnt = 0;
  int n_cycles = 0;
  int low_run = 0;
  int last_low = 0;
  logic prev_cs = 1'b1;

  bus_t exp_bus[$];
  bus_t obs_bus[$];
  rsp_t exp_rsp[$];
  rsp_t obs_rsp[$];

  // target: 0 = DTACK after dly clks, 1 = never, 2 = stuck low, 3 = DTACK = cs_n
  int mode = 0;
  int dly = 3;
  int tcnt = 0;
  logic dt_reg = 1'b1;
  logic [7:0] rdat [2];

  always #5 clk = ~clk;

  xosera_bus_initiator #(
    .SETUP_CYCLES(SETUP),
    .STROBE_MIN(SMIN),
    .RECOVERY_CYCLES(REC),
    .TIMEOUT_CYCLES(TMO),
    .TW(8)
  ) dut (
    .clk(clk),
    .reset_i(reset_i),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_rd_nwr_i(req_rd_nwr),
    .req_word_i(req_word),
    .req_odd_i(req_odd),
    .req_reg_i(req_reg),
    .req_data_i(req_data),
    .rsp_valid_o(rsp_valid),
    .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err),
    .bus_cs_n_o(bus_cs_n),
    .bus_rd_nwr_o(bus_rd_nwr),
    .bus_addr_o(bus_addr),
    .bus_data_o(bus_data_o),
    .bus_data_oe_o(bus_data_oe),
    .bus_data_i(bus_din),
    .bus_dtack_n_i(bus_dtack_n)
  );

  assign bus_dtack_n = (mode == 3) ? bus_cs_n :
                       (mode == 2) ? 1'b0 :
                       (mode == 1) ? 1'b1 : dt_reg;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!bus_cs_n) begin
      bus_din <= rdat[bus_addr[0]];
      if (tcnt >= dly) dt_reg <= 1'b0;
      else             tcnt <= tcnt + 1;
    end else begin
      tcnt   <= 0;
      dt_reg <= 1'b1;
    end
  end

  always @(negedge clk) begin
    prev_cs <= bus_cs_n;
    low_run <= bus_cs_n ? 0 : low_run + 1;
    if (bus_cs_n && !prev_cs) last_low <= low_run;
    if (!reset_i) begin
      if (req_valid && req_ready) acc_cyc <= cyc + 1;
      if (!bus_cs_n && prev_cs) begin
        obs_bus.push_back({bus_addr, bus_rd_nwr, bus_data_o, bus_data_oe});
        n_cycles <= n_cycles + 1;
      end
      if (rsp_valid) begin
        obs_rsp.push_back({rsp_data, rsp_err});
        rsp_cnt <= rsp_cnt + 1;
        rsp_cyc <= cyc;
      end
    end
  end

  task automatic send(input logic rd, input logic word, input logic odd,
                      input logic [3:0] r, input logic [15:0] d);
    @(negedge clk);
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
    req_rd_nwr = rd;
    req_word   = word;
    req_odd    = odd;
    req_reg    = r;
    req_data   = d;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    req_rd_nwr = 1'($urandom_range(0, 1));
    req_word   = 1'($urandom_range(0, 1));
    req_odd    = 1'($urandom_range(0, 1));
    req_reg    = 4'($urandom);
    req_data   = 16'($urandom);
  endtask

  task automatic wait_rsp(input int b, output bit got);
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rsp_cnt > b) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus_cs_n, bus_rd_nwr, bus_addr, bus_data_o, bus_data_oe,
         req_ready, rsp_valid, rsp_data, rsp_err} !==
        {1'b1, 1'b1, 5'h00, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0})
      $display("FAIL reset_state got cs=%b rw=%b a=%h d=%h oe=%b rdy=%b rv=%b rd=%h err=%b want 1 1 00 00 0 1 0 0000 0",
               bus_cs_n, bus_rd_nwr, bus_addr, bus_data_o, bus_data_oe,
               req_ready, rsp_valid, rsp_data, rsp_err);
    else passed++;
    reset_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_word_write();
    int b;
    bit got;
    bus_t e, o;
    rsp_t er, orr;
    mode = 0;
    dly  = 3;
    exp_bus.push_back(bus_t'{5'h06, 1'b0, 8'hA5, 1'b1});
    exp_bus.push_back(bus_t'{5'h07, 1'b0, 8'h5A, 1'b1});
    exp_rsp.push_back(rsp_t'{16'h0000, 1'b0});
    b = rsp_cnt;
    send(1'b0, 1'b1, 1'b0, 4'h3, 16'hA55A);
    wait_rsp(b, got);
    total++;
    if (!got) $display("FAIL ww_timeout got no rsp want rsp");
    else passed++;
    while (exp_bus.size() > 0 && obs_bus.size() > 0) begin
      e = exp_bus.pop_front();
      o = obs_bus.pop_front();
      total++;
      if (o !== e) $display("FAIL ww_bus got %h want %h", o, e);
      else passed++;
    end
    total++;
    if (exp_bus.size() != 0 || obs_bus.size() != 0)
      $display("FAIL ww_bus_count got %0d left want 0", exp_bus.size() + obs_bus.size());
    else passed++;
    exp_bus.delete();
    obs_bus.delete();
    er  = exp_rsp.pop_front();
    orr = (obs_rsp.size() > 0) ? obs_rsp.pop_front() : rsp_t'{16'hxxxx, 1'bx};
    total++;
    if (orr !== er) $display("FAIL ww_rsp got %h want %h", orr, er);
    else passed++;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || obs_rsp.size() != 0)
      $display("FAIL ww_pulse got rv=%b rdy=%b extra=%0d want 0 1 0",
               rsp_valid, req_ready, obs_rsp.size());
    else passed++;
    obs_rsp.delete();
  endtask

  task automatic test_word_read();
    int b;
    bit got;
    bus_t e, o;
    rsp_t er, orr;
    mode = 0;
    dly  = 2;
    rdat[0] = 8'h12;
    rdat[1] = 8'h34;
    exp_bus.push_back(bus_t'{5'h04, 1'b1, 8'h00, 1'b0});
    exp_bus.push_back(bus_t'{5'h05, 1'b1, 8'h00, 1'b0});
    exp_rsp.push_back(rsp_t'{16'h1234, 1'b0});
    b = rsp_cnt;
    send(1'b1, 1'b1, 1'b0, 4'h2, 16'hFFFF);
    wait_rsp(b, got);
    while (exp_bus.size() > 0 && obs_bus.size() > 0) begin
      e = exp_bus.pop_front();
      o = obs_bus.pop_front();
      total++;
      if (o.addr !== e.addr || o.rd !== e.rd || o.oe !== e.oe)
        $display("FAIL wr_bus got a=%h rw=%b oe=%b want a=%h rw=%b oe=%b",
                 o.addr, o.rd, o.oe, e.addr, e.rd, e.oe);
      else passed++;
    end
    total++;
    if (exp_bus.size() != 0 || obs_bus.size() != 0)
      $display("FAIL wr_bus_count got %0d left want 0", exp_bus.size() + obs_bus.size());
    else passed++;
    exp_bus.delete();
    obs_bus.delete();
    er  = exp_rsp.pop_front();
    orr = (obs_rsp.size() > 0) ? obs_rsp.pop_front() : rsp_t'{16'hxxxx, 1'bx};
    total++;
    if (orr !== er) $display("FAIL wr_rsp got %h want %h", orr, er);
    else passed++;
    obs_rsp.delete();
  endtask

  task automatic test_byte(input logic rd, input logic odd, input logic [3:0] r,
                           input logic [15:0] d, input logic [7:0] rb,
                           input logic [15:0] want_rsp);
    int b, c;
    bit got;
    bus_t e, o;
    rsp_t er, orr;
    mode = 0;
    dly  = 1;
    rdat[0] = rb;
    rdat[1] = rb;
    e = bus_t'{{r, odd}, rd, (rd ? 8'h00 : (odd ? d[7:0] : d[15:8])), !rd};
    exp_rsp.push_back(rsp_t'{want_rsp, 1'b0});
    b = rsp_cnt;
    c = n_cycles;
    send(rd, 1'b0, odd, r, d);
    wait_rsp(b, got);
    total++;
    if (n_cycles - c != 1) $display("FAIL byte_cycles got %0d want 1", n_cycles - c);
    else passed++;
    o = (obs_bus.size() > 0) ? obs_bus.pop_front() : bus_t'('x);
    if (rd) o.data = 8'h00;
    total++;
    if (o !== e) $display("FAIL byte_bus got %h want %h", o, e);
    else passed++;
    er  = exp_rsp.pop_front();
    orr = (obs_rsp.size() > 0) ? obs_rsp.pop_front() : rsp_t'{16'hxxxx, 1'bx};
    total++;
    if (orr !== er) $display("FAIL byte_rsp got %h want %h", orr, er);
    else passed++;
    obs_bus.delete();
    obs_rsp.delete();
  endtask

  task automatic test_timeout();
    int b, c;
    bit got;
    bus_t o;
    rsp_t orr;
    mode = 1;
    exp_rsp.push_back(rsp_t'{16'h0000, 1'b1});
    b = rsp_cnt;
    c = n_cycles;
    send(1'b1, 1'b1, 1'b0, 4'h4, 16'h0000);
    wait_rsp(b, got);
    total++;
    if (last_low != TMO) $display("FAIL tmo_strobe_len got %0d want %0d", last_low, TMO);
    else passed++;
    total++;
    if (n_cycles - c != 1) $display("FAIL tmo_cycles got %0d want 1", n_cycles - c);
    else passed++;
    o = (obs_bus.size() > 0) ? obs_bus.pop_front() : bus_t'('x);
    total++;
    if (o.addr !== 5'h08 || o.rd !== 1'b1) $display("FAIL tmo_bus got a=%h rw=%b want 08 1", o.addr, o.rd);
    else passed++;
    orr = (obs_rsp.size() > 0) ? obs_rsp.pop_front() : rsp_t'{16'hxxxx, 1'bx};
    total++;
    if (orr !== exp_rsp[0]) $display("FAIL tmo_rsp got %h want %h", orr, exp_rsp[0]);
    else passed++;
    exp_rsp.delete();
    obs_bus.delete();
    obs_rsp.delete();
    mode = 0;
  endtask

  task automatic test_stuck_dtack();
    int b;
    bit got;
    bus_t o;
    rsp_t orr;
    mode = 2;
    repeat (4) @(negedge clk);
    exp_bus.push_back(bus_t'{5'h0D, 1'b0, 8'hEE, 1'b1});
    exp_rsp.push_back(rsp_t'{16'h0000, 1'b1});
    b = rsp_cnt;
    send(1'b0, 1'b0, 1'b1, 4'h6, 16'h00EE);
    wait_rsp(b, got);
    total++;
    if (last_low != SMIN) $display("FAIL stuck_strobe_len got %0d want %0d", last_low, SMIN);
    else passed++;
    o = (obs_bus.size() > 0) ? obs_bus.pop_front() : bus_t'('x);
    total++;
    if (o !== exp_bus[0]) $display("FAIL stuck_bus got %h want %h", o, exp_bus[0]);
    else passed++;
    orr = (obs_rsp.size() > 0) ? obs_rsp.pop_front() : rsp_t'{16'hxxxx, 1'bx};
    total++;
    if (orr !== exp_rsp[0]) $display("FAIL stuck_rsp got %h want %h", orr, exp_rsp[0]);
    else passed++;
    exp_bus.delete();
    exp_rsp.delete();
    obs_bus.delete();
    obs_rsp.delete();
    mode = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_latency();
    int b, lat;
    bit got;
    bus_t o;
    // DTACK follows cs_n directly, so each strobe and release costs the
    // two synchronizer clocks plus one decision clock
    lat = 2 * (SETUP + 3 + 3 + REC);
    mode = 3;
    repeat (2) @(negedge clk);
    b = rsp_cnt;
    send(1'b0, 1'b1, 1'b0, 4'h0, 16'h1234);
    wait_rsp(b, got);
    total++;
    if (rsp_cyc - acc_cyc != lat)
      $display("FAIL latency got %0d want %0d", rsp_cyc - acc_cyc, lat);
    else passed++;
    o = (obs_bus.size() > 1) ? obs_bus[1] : bus_t'('x);
    total++;
    if (o !== bus_t'{5'h01, 1'b0, 8'h34, 1'b1})
      $display("FAIL lat_bus2 got %h want %h", o, bus_t'{5'h01, 1'b0, 8'h34, 1'b1});
    else passed++;
    total++;
    if (obs_rsp.size() != 1 || obs_rsp[0] !== rsp_t'{16'h0000, 1'b0})
      $display("FAIL lat_rsp got n=%0d want one rsp 0000 err 0", obs_rsp.size());
    else passed++;
    obs_bus.delete();
    obs_rsp.delete();
    mode = 0;
  endtask

  task automatic test_reset_mid_strobe();
    int b, c;
    bit got;
    bus_t o;
    rsp_t orr;
    mode = 0;
    dly  = 3;
    b = rsp_cnt;
    c = n_cycles;
    send(1'b0, 1'b1, 1'b0, 4'h7, 16'hBEEF);
    for (int i = 0; i < 50 && bus_cs_n; i++) @(negedge clk);
    @(negedge clk);
    #2 reset_i = 1'b1;
    #1;
    total++;
    if (bus_cs_n !== 1'b1 || bus_data_oe !== 1'b0)
      $display("FAIL rst_async got cs=%b oe=%b want 1 0", bus_cs_n, bus_data_oe);
    else passed++;
    o = (obs_bus.size() > 0) ? obs_bus.pop_front() : bus_t'('x);
    total++;
    if (o !== bus_t'{5'h0E, 1'b0, 8'hBE, 1'b1})
      $display("FAIL rst_bus got %h want %h", o, bus_t'{5'h0E, 1'b0, 8'hBE, 1'b1});
    else passed++;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (rsp_cnt != b || n_cycles != c + 1 || obs_rsp.size() != 0)
      $display("FAIL rst_no_rsp got rsp=%0d cyc=%0d want rsp=0 cyc=1", rsp_cnt - b, n_cycles - c);
    else passed++;
    total++;
    if ({rsp_data, rsp_err, req_ready} !== {16'h0000, 1'b0, 1'b1})
      $display("FAIL rst_idle got d=%h err=%b rdy=%b want 0000 0 1", rsp_data, rsp_err, req_ready);
    else passed++;
    obs_bus.delete();
    rdat[0] = 8'h56;
    rdat[1] = 8'h78;
    b = rsp_cnt;
    send(1'b1, 1'b1, 1'b0, 4'h2, 16'h0000);
    wait_rsp(b, got);
    total++;
    if (obs_bus.size() != 2 || obs_bus[0].addr !== 5'h04 || obs_bus[1].addr !== 5'h05)
      $display("FAIL rst_next_bus got n=%0d want 2 cycles 04 05", obs_bus.size());
    else passed++;
    orr = (obs_rsp.size() > 0) ? obs_rsp.pop_front() : rsp_t'{16'hxxxx, 1'bx};
    total++;
    if (orr !== rsp_t'{16'h5678, 1'b0}) $display("FAIL rst_next_rsp got %h want %h", orr, rsp_t'{16'h5678, 1'b0});
    else passed++;
    obs_bus.delete();
    obs_rsp.delete();
  endtask

  initial begin
    rdat[0] = 8'h00;
    rdat[1] = 8'h00;
    test_reset();
    test_word_write();
    test_word_read();
    test_byte(1'b1, 1'b1, 4'h1, 16'h0000, 8'h9C, 16'h009C);
    test_byte(1'b0, 1'b0, 4'h5, 16'h3C77, 8'h00, 16'h009C);
    test_timeout();
    test_stuck_dtack();
    test_latency();
    test_reset_mid_strobe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

endmodule
